// File: rtl/decode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_sequencer: registered instruction decoder with L16B sequencer  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module decode_sequencer #(
  parameter int L16_BEATS = 4,
  parameter int STRIDE    = 4,
  parameter int OFFW      = 8
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            Instr_Valid,
  input  logic [5:0]      OpCode,
  input  logic [5:0]      Funct,
  input  logic            Flush,
  input  logic            Hold,
  output logic            Ready,
  output logic            Ctrl_Valid,
  output logic [1:0]      RegDest,
  output logic            RegWrite,
  output logic            AluSrc,
  output logic [4:0]      AluOp,
  output logic            MemWrite,
  output logic            MemRead,
  output logic            Branch,
  output logic [1:0]      MemToReg,
  output logic            SignExt,
  output logic            Jump,
  output logic            JumpMux,
  output logic [1:0]      ByteSel,
  output logic [2:0]      BCControl,
  output logic            BranchSourceMux,
  output logic            JAL,
  output logic [1:0]      L16B,
  output logic [OFFW-1:0] Beat_Offset,
  output logic            Beat_Last,
  output logic            Illegal
);

  localparam int BW = (L16_BEATS > 1) ? $clog2(L16_BEATS) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SEQ = 1'b1} state_t;

  typedef struct packed {
    logic [1:0] reg_dest;
    logic       reg_write;
    logic       alu_src;
    logic [4:0] alu_op;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic [1:0] mem_to_reg;
    logic       sign_ext;
    logic       jump;
    logic       jump_mux;
    logic [1:0] byte_sel;
    logic [2:0] bc_control;
    logic       branch_source_mux;
    logic       jal;
    logic [1:0] l16b;
  } ctrl_t;

  function automatic ctrl_t idle_word();
    ctrl_t w;
    w        = '0;
    w.alu_op = 5'b00001;
    return w;
  endfunction

  function automatic logic [1:0] byte_sel_of(input logic [1:0] low);
    case (low)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              valid_q, valid_d;
  ctrl_t             word_q, word_d;
  logic              illegal_q, illegal_d;
  logic              last_q, last_d;
  logic [OFFW-1:0]   offset_q, offset_d;

  ctrl_t             dec_word;
  logic              dec_illegal;
  logic              dec_multi;
  logic              go_idle;

  always_comb begin
    dec_word    = idle_word();
    dec_illegal = 1'b0;
    dec_multi   = 1'b0;
    case (OpCode)
      6'b000000: begin
        dec_word.reg_write = 1'b1;
        dec_word.jump_mux  = 1'b1;
        dec_word.sign_ext  = 1'b1;
        dec_word.alu_op    = 5'b00000;
        if (Funct == 6'b001000) begin
          dec_word.jump      = 1'b1;
          dec_word.reg_write = 1'b0;
        end
      end
      6'b000010: dec_word.jump = 1'b1;
      6'b000011: begin
        dec_word.jump       = 1'b1;
        dec_word.jal        = 1'b1;
        dec_word.reg_write  = 1'b1;
        dec_word.reg_dest   = 2'b10;
        dec_word.mem_to_reg = 2'b10;
      end
      6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001, 6'b111110: begin
        dec_word.branch     = 1'b1;
        dec_word.mem_to_reg = 2'b11;
        case (OpCode)
          6'b000100: {dec_word.alu_op, dec_word.bc_control} = {5'b01110, 3'b000};
          6'b000101: {dec_word.alu_op, dec_word.bc_control} = {5'b01111, 3'b101};
          6'b000110: {dec_word.alu_op, dec_word.bc_control} = {5'b10010, 3'b011};
          6'b000111: {dec_word.alu_op, dec_word.bc_control} = {5'b10001, 3'b010};
          6'b000001: begin
            {dec_word.alu_op, dec_word.bc_control} = {5'b10000, 3'b001};
            dec_word.branch_source_mux = 1'b1;
          end
          default:   {dec_word.alu_op, dec_word.bc_control} = {5'b10000, 3'b110};
        endcase
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec_word.reg_dest  = 2'b01;
        dec_word.reg_write = 1'b1;
        dec_word.alu_src   = 1'b1;
        dec_word.sign_ext  = 1'b1;
        case (OpCode[2:0])
          3'b000: dec_word.alu_op = 5'b00001;
          3'b001: dec_word.alu_op = 5'b00111;
          3'b010: dec_word.alu_op = 5'b01010;
          3'b011: dec_word.alu_op = 5'b01011;
          3'b100: begin dec_word.alu_op = 5'b00100; dec_word.sign_ext = 1'b0; end
          3'b101: begin dec_word.alu_op = 5'b00011; dec_word.sign_ext = 1'b0; end
          3'b110: begin dec_word.alu_op = 5'b00101; dec_word.sign_ext = 1'b0; end
          default: dec_word.alu_op = 5'b10011;
        endcase
      end
      6'b100000, 6'b100001, 6'b100011: begin
        dec_word.mem_read   = 1'b1;
        dec_word.mem_to_reg = 2'b01;
        dec_word.reg_write  = 1'b1;
        dec_word.byte_sel   = byte_sel_of(OpCode[1:0]);
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec_word.mem_write = 1'b1;
        dec_word.byte_sel  = byte_sel_of(OpCode[1:0]);
      end
      6'b011100: dec_word.alu_op = 5'b01100;
      6'b011111: dec_word.alu_op = 5'b01101;
      6'b111111: begin
        dec_word.reg_write = 1'b1;
        dec_word.jump_mux  = 1'b1;
        dec_word.l16b      = 2'b01;
      end
      6'b110011: begin dec_word.l16b = 2'b10; dec_multi = 1'b1; end
      6'b111011: begin dec_word.l16b = 2'b11; dec_multi = 1'b1; end
      default:   dec_illegal = 1'b1;
    endcase
  end

  assign Ready = (state_q == IDLE) & ~Hold;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    valid_d   = valid_q;
    word_d    = word_q;
    illegal_d = illegal_q;
    last_d    = last_q;
    offset_d  = offset_q;
    go_idle   = 1'b0;
    if (Flush) begin
      go_idle = 1'b1;
    end else if (!Hold) begin
      if (state_q == SEQ) begin
        // The final beat has been on the outputs for a cycle; leave now.
        if (last_q) begin
          go_idle = 1'b1;
        end else begin
          valid_d  = 1'b1;
          offset_d = OFFW'(beat_q) * OFFW'(STRIDE);
          last_d   = (beat_q == BW'(L16_BEATS - 1));
          beat_d   = last_d ? '0 : beat_q + 1'b1;
        end
      end else if (Instr_Valid) begin
        valid_d   = 1'b1;
        word_d    = dec_word;
        illegal_d = dec_illegal;
        offset_d  = '0;
        last_d    = ~dec_multi;
        beat_d    = dec_multi ? BW'(1) : '0;
        state_d   = dec_multi ? SEQ : IDLE;
      end else begin
        go_idle = 1'b1;
      end
    end
    if (go_idle) begin
      state_d   = IDLE;
      beat_d    = '0;
      valid_d   = 1'b0;
      word_d    = idle_word();
      illegal_d = 1'b0;
      last_d    = 1'b0;
      offset_d  = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      valid_q   <= 1'b0;
      word_q    <= idle_word();
      illegal_q <= 1'b0;
      last_q    <= 1'b0;
      offset_q  <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      valid_q   <= valid_d;
      word_q    <= word_d;
      illegal_q <= illegal_d;
      last_q    <= last_d;
      offset_q  <= offset_d;
    end
  end

  assign Ctrl_Valid      = valid_q;
  assign RegDest         = word_q.reg_dest;
  assign RegWrite        = word_q.reg_write;
  assign AluSrc          = word_q.alu_src;
  assign AluOp           = word_q.alu_op;
  assign MemWrite        = word_q.mem_write;
  assign MemRead         = word_q.mem_read;
  assign Branch          = word_q.branch;
  assign MemToReg        = word_q.mem_to_reg;
  assign SignExt         = word_q.sign_ext;
  assign Jump            = word_q.jump;
  assign JumpMux         = word_q.jump_mux;
  assign ByteSel         = word_q.byte_sel;
  assign BCControl       = word_q.bc_control;
  assign BranchSourceMux = word_q.branch_source_mux;
  assign JAL             = word_q.jal;
  assign L16B            = word_q.l16b;
  assign Beat_Offset     = offset_q;
  assign Beat_Last       = last_q;
  assign Illegal         = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_decode_sequencer: directed checks of decode and L16B sequencing    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_decode_sequencer;

  logic       Clock, Reset_n, Instr_Valid, Flush, Hold;
  logic [5:0] OpCode, Funct;
  logic       Ready, Ctrl_Valid, RegWrite, AluSrc, MemWrite, MemRead, Branch;
  logic       SignExt, Jump, JumpMux, BranchSourceMux, JAL, Beat_Last, Illegal;
  logic [1:0] RegDest, MemToReg, ByteSel, L16B;
  logic [2:0] BCControl;
  logic [4:0] AluOp;
  logic [7:0] Beat_Offset;

  int total = 0;
  int bad   = 0;

  decode_sequencer #(.L16_BEATS(4), .STRIDE(4), .OFFW(8)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Instr_Valid(Instr_Valid),
    .OpCode(OpCode), .Funct(Funct), .Flush(Flush), .Hold(Hold),
    .Ready(Ready), .Ctrl_Valid(Ctrl_Valid), .RegDest(RegDest),
    .RegWrite(RegWrite), .AluSrc(AluSrc), .AluOp(AluOp),
    .MemWrite(MemWrite), .MemRead(MemRead), .Branch(Branch),
    .MemToReg(MemToReg), .SignExt(SignExt), .Jump(Jump),
    .JumpMux(JumpMux), .ByteSel(ByteSel), .BCControl(BCControl),
    .BranchSourceMux(BranchSourceMux), .JAL(JAL), .L16B(L16B),
    .Beat_Offset(Beat_Offset), .Beat_Last(Beat_Last), .Illegal(Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [25:0] obs_w;
  assign obs_w = {RegDest, RegWrite, AluSrc, AluOp, MemWrite, MemRead, Branch,
                  MemToReg, SignExt, Jump, JumpMux, ByteSel, BCControl,
                  BranchSourceMux, JAL, L16B};

  function automatic logic [25:0] cw(
    input logic [1:0] rd, input logic rw, input logic as, input logic [4:0] op,
    input logic mw, input logic mr, input logic br, input logic [1:0] m2r,
    input logic se, input logic j, input logic jm, input logic [1:0] bs,
    input logic [2:0] bc, input logic bsm, input logic jal, input logic [1:0] l16);
    return {rd, rw, as, op, mw, mr, br, m2r, se, j, jm, bs, bc, bsm, jal, l16};
  endfunction

  function automatic logic [25:0] idle_w();
    return cw(2'b00,0,0,5'b00001,0,0,0,2'b00,0,0,0,2'b00,3'b000,0,0,2'b00);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, Ctrl_Valid, 0);
    chk({tag, "_word"}, obs_w, idle_w());
    chk({tag, "_ill"}, Illegal, 0);
    chk({tag, "_last"}, Beat_Last, 0);
    chk({tag, "_off"}, Beat_Offset, 0);
  endtask

  logic [5:0]  t_op [15];
  logic [5:0]  t_fn [15];
  logic [25:0] t_exp[15];
  logic        t_ill[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 0; Instr_Valid = 0; OpCode = 0; Funct = 0; Flush = 0; Hold = 0;
    for (int i = 0; i < 15; i++) begin t_fn[i] = 6'b000000; t_ill[i] = 1'b0; end
    t_op[0]  = 6'b000000; t_fn[0] = 6'b100000;
    t_exp[0] = cw(2'b00,1,0,5'b00000,0,0,0,2'b00,1,0,1,2'b00,3'b000,0,0,2'b00);
    t_op[1]  = 6'b000000; t_fn[1] = 6'b001000;
    t_exp[1] = cw(2'b00,0,0,5'b00000,0,0,0,2'b00,1,1,1,2'b00,3'b000,0,0,2'b00);
    t_op[2]  = 6'b000010;
    t_exp[2] = cw(2'b00,0,0,5'b00001,0,0,0,2'b00,0,1,0,2'b00,3'b000,0,0,2'b00);
    t_op[3]  = 6'b000011;
    t_exp[3] = cw(2'b10,1,0,5'b00001,0,0,0,2'b10,0,1,0,2'b00,3'b000,0,1,2'b00);
    t_op[4]  = 6'b000101;
    t_exp[4] = cw(2'b00,0,0,5'b01111,0,0,1,2'b11,0,0,0,2'b00,3'b101,0,0,2'b00);
    t_op[5]  = 6'b000001;
    t_exp[5] = cw(2'b00,0,0,5'b10000,0,0,1,2'b11,0,0,0,2'b00,3'b001,1,0,2'b00);
    t_op[6]  = 6'b111110;
    t_exp[6] = cw(2'b00,0,0,5'b10000,0,0,1,2'b11,0,0,0,2'b00,3'b110,0,0,2'b00);
    t_op[7]  = 6'b001101;
    t_exp[7] = cw(2'b01,1,1,5'b00011,0,0,0,2'b00,0,0,0,2'b00,3'b000,0,0,2'b00);
    t_op[8]  = 6'b100001;
    t_exp[8] = cw(2'b00,1,0,5'b00001,0,1,0,2'b01,0,0,0,2'b11,3'b000,0,0,2'b00);
    t_op[9]  = 6'b101011;
    t_exp[9] = cw(2'b00,0,0,5'b00001,1,0,0,2'b00,0,0,0,2'b00,3'b000,0,0,2'b00);
    t_op[10] = 6'b111111;
    t_exp[10] = cw(2'b00,1,0,5'b00001,0,0,0,2'b00,0,0,1,2'b00,3'b000,0,0,2'b01);
    t_op[11] = 6'b000110;
    t_exp[11] = cw(2'b00,0,0,5'b10010,0,0,1,2'b11,0,0,0,2'b00,3'b011,0,0,2'b00);
    t_op[12] = 6'b001111;
    t_exp[12] = cw(2'b01,1,1,5'b10011,0,0,0,2'b00,1,0,0,2'b00,3'b000,0,0,2'b00);
    t_op[13] = 6'b011111;
    t_exp[13] = cw(2'b00,0,0,5'b01101,0,0,0,2'b00,0,0,0,2'b00,3'b000,0,0,2'b00);
    t_op[14] = 6'b010000; t_ill[14] = 1'b1;
    t_exp[14] = idle_w();

    // Reset state
    tick(); tick();
    chk_idle("reset");
    chk("reset_ready", Ready, 1);

    // First acceptance right after reset release: ADDI
    Reset_n = 1; Instr_Valid = 1; OpCode = 6'b001000;
    #1 chk("ready_post_reset", Ready, 1);
    tick();
    chk("addi_valid", Ctrl_Valid, 1);
    chk("addi_regdest", RegDest, 2'b01);
    chk("addi_regwrite", RegWrite, 1);
    chk("addi_alusrc", AluSrc, 1);
    chk("addi_aluop", AluOp, 5'b00001);
    chk("addi_last", Beat_Last, 1);
    chk("addi_off", Beat_Offset, 0);
    Instr_Valid = 0;
    tick();
    chk_idle("no_accept");

    // Back-to-back single-beat decodes
    for (int i = 0; i < 15; i++) begin
      Instr_Valid = 1; OpCode = t_op[i]; Funct = t_fn[i];
      tick();
      chk($sformatf("dec%0d_word", i), obs_w, t_exp[i]);
      chk($sformatf("dec%0d_valid", i), Ctrl_Valid, 1);
      chk($sformatf("dec%0d_ill", i), Illegal, t_ill[i]);
      chk($sformatf("dec%0d_last", i), Beat_Last, 1);
      chk($sformatf("dec%0d_off", i), Beat_Offset, 0);
    end
    Instr_Valid = 0; Funct = 0;
    tick();
    chk_idle("after_table");

    // L16BW: four beats, an ADDI waiting behind it must not be taken early
    Instr_Valid = 1; OpCode = 6'b110011;
    tick();
    OpCode = 6'b001000;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bw%0d_ready", k), Ready, 0);
      chk($sformatf("bw%0d_valid", k), Ctrl_Valid, 1);
      chk($sformatf("bw%0d_off", k), Beat_Offset, 4 * k);
      chk($sformatf("bw%0d_last", k), Beat_Last, (k == 3) ? 1 : 0);
      chk($sformatf("bw%0d_l16b", k), L16B, 2'b10);
      tick();
    end
    chk("bw_end_ready", Ready, 1);
    chk("bw_end_valid", Ctrl_Valid, 0);
    tick();
    chk("bw_next_word", obs_w,
        cw(2'b01,1,1,5'b00001,0,0,0,2'b00,1,0,0,2'b00,3'b000,0,0,2'b00));
    chk("bw_next_valid", Ctrl_Valid, 1);

    // Hold in IDLE freezes outputs and blocks acceptance
    Hold = 1; OpCode = 6'b000011;
    #1 chk("hold_idle_ready", Ready, 0);
    tick();
    chk("hold_idle_word", AluSrc, 1);
    chk("hold_idle_valid", Ctrl_Valid, 1);
    Hold = 0;
    tick();
    chk("post_hold_jal", JAL, 1);
    Instr_Valid = 0;

    // L16BF with a three-cycle Hold on beat 1
    Instr_Valid = 1; OpCode = 6'b111011;
    tick();
    Instr_Valid = 0;
    chk("bf0_off", Beat_Offset, 0);
    chk("bf0_l16b", L16B, 2'b11);
    tick();
    chk("bf1_off", Beat_Offset, 4);
    Hold = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bf_hold%0d_off", k), Beat_Offset, 4);
      chk($sformatf("bf_hold%0d_valid", k), Ctrl_Valid, 1);
      chk($sformatf("bf_hold%0d_last", k), Beat_Last, 0);
      chk($sformatf("bf_hold%0d_ready", k), Ready, 0);
    end
    Hold = 0;
    tick();
    chk("bf2_off", Beat_Offset, 8);
    chk("bf2_last", Beat_Last, 0);
    tick();
    chk("bf3_off", Beat_Offset, 12);
    chk("bf3_last", Beat_Last, 1);
    chk("bf3_l16b", L16B, 2'b11);
    tick();
    chk("bf_end_valid", Ctrl_Valid, 0);

    // Flush with Hold during beat 2 drops the sequence and the presented BEQ
    Instr_Valid = 1; OpCode = 6'b110011;
    tick();
    Instr_Valid = 0;
    tick(); tick();
    chk("fl_beat2_off", Beat_Offset, 8);
    Flush = 1; Hold = 1; Instr_Valid = 1; OpCode = 6'b000100;
    tick();
    chk_idle("flush");
    Flush = 0; Hold = 0;
    #1 chk("flush_ready", Ready, 1);
    tick();
    chk("beq_word", obs_w,
        cw(2'b00,0,0,5'b01110,0,0,1,2'b11,0,0,0,2'b00,3'b000,0,0,2'b00));
    chk("beq_last", Beat_Last, 1);
    Instr_Valid = 0;
    tick();

    // Asynchronous reset mid-sequence, between clock edges
    Instr_Valid = 1; OpCode = 6'b110011;
    tick();
    Instr_Valid = 0;
    tick();
    chk("ar_beat1_off", Beat_Offset, 4);
    #3 Reset_n = 0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_ready", Ready, 1);
    #2 Reset_n = 1;
    tick();
    chk_idle("no_resume");
    chk("no_resume_ready", Ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
